// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// memory-handshake FSM states, the x0 register index and the default counter width.
package hazard_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    localparam logic [4:0] REG_X0        = 5'd0;
    localparam int         DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and data-memory handshake control for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to build the three saturating performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             stall_o,
    output logic             stall_all_o,
    output logic             flush_o,
    output logic             mem_cmd_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
);

    mem_state_e state_q;
    mem_state_e state_d;
    logic       mem_cmd_raw;
    logic       stall_all_raw;
    logic       load_use_raw;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack seen outside WAIT is stale and deliberately dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (mem_req_i) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ack_i) state_d = MEM_DONE;
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        mem_cmd_raw   = 1'b0;
        stall_all_raw = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                mem_cmd_raw   = mem_req_i;
                stall_all_raw = mem_req_i;
            end
            MEM_WAIT: stall_all_raw = 1'b1;
            default: begin
                mem_cmd_raw   = 1'b0;
                stall_all_raw = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_use_raw = ex_memread_i && (ex_rd_i != REG_X0) &&
                       ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    end

    // Every control output is held low while reset is asserted.
    assign stall_o     = rst_i && load_use_raw;
    assign stall_all_o = rst_i && stall_all_raw;
    assign mem_cmd_o   = rst_i && mem_cmd_raw;
    assign flush_o     = rst_i && branch_taken_i && !load_use_raw && !stall_all_raw;

`ifdef HAZARD_PERF_CNT_EN
    logic cnt_clr;
    logic cnt_en [3];

    assign cnt_clr   = !rst_i;
    assign cnt_en[0] = stall_o && !stall_all_o;
    assign cnt_en[1] = flush_o;
    assign cnt_en[2] = stall_all_o;

    logic [CNT_W-1:0] cnt_val [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .clr_i (cnt_clr),
            .en_i  (cnt_en[gi]),
            .cnt_o (cnt_val[gi])
        );
    end

    assign stall_cnt_o   = cnt_val[0];
    assign flush_cnt_o   = cnt_val[1];
    assign memwait_cnt_o = cnt_val[2];
`else
    assign stall_cnt_o   = '0;
    assign flush_cnt_o   = '0;
    assign memwait_cnt_o = '0;
`endif

endmodule
